// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the N-master AXI4-lite round-robin arbiter.
package axi_arb_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit searching
// ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] w_cand;

  // Walk candidates from the farthest to the nearest so the nearest set bit wins
  always_comb begin
    gnt_idx = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IW'((32'(ptr) + N - 1 - k) % N);
      if (req[w_cand]) gnt_idx = w_cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI4-lite arbiter, independent round-robin read and
// write channels, one outstanding transaction per channel.
// Optional per-master completion counters: define ARB_PERF_CNT_EN.
module axi_lite_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STRB_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [N_MASTERS-1:0]          m_arvalid,
  output logic [N_MASTERS-1:0]          m_arready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [N_MASTERS-1:0]          m_awvalid,
  output logic [N_MASTERS-1:0]          m_awready,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
  input  logic [N_MASTERS-1:0]          m_wvalid,
  output logic [N_MASTERS-1:0]          m_wready,
  output logic [1:0]                    m_bresp,
  output logic [N_MASTERS-1:0]          m_bvalid,
  input  logic [N_MASTERS-1:0]          m_bready,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  input  logic [1:0]                    s_bresp,
  input  logic                          s_bvalid,
  output logic                          s_bready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [N_MASTERS*32-1:0]       perf_rd_cnt,
  output logic [N_MASTERS*32-1:0]       perf_wr_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(N_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

  rd_state_t          r_rstate;
  logic [IDX_W-1:0]   r_rgnt, r_rptr;
  logic [IDX_W-1:0]   w_rpick;
  logic               w_rany;
  logic               w_ar_hs, w_r_hs;

  wr_state_t          r_wstate;
  logic [IDX_W-1:0]   r_wgnt, r_wptr;
  logic               r_aw_done, r_w_done;
  logic [IDX_W-1:0]   w_wpick;
  logic               w_wany;
  logic               w_aw_hs, w_w_hs, w_b_hs;

  rr_picker #(.N(N_MASTERS)) u_rd_pick (
    .req     (m_arvalid),
    .ptr     (r_rptr),
    .gnt_idx (w_rpick),
    .any     (w_rany)
  );

  rr_picker #(.N(N_MASTERS)) u_wr_pick (
    .req     (m_awvalid | m_wvalid),
    .ptr     (r_wptr),
    .gnt_idx (w_wpick),
    .any     (w_wany)
  );

  assign w_ar_hs = s_arvalid & s_arready;
  assign w_r_hs  = s_rvalid  & s_rready;
  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid  & s_wready;
  assign w_b_hs  = s_bvalid  & s_bready;

  // Read channel FSM: grant, address phase, data phase, then rotate pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rgnt   <= '0;
      r_rptr   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_rany) begin
          r_rgnt   <= w_rpick;
          r_rstate <= R_ADDR;
        end
        R_ADDR: if (w_ar_hs) r_rstate <= R_DATA;
        R_DATA: if (w_r_hs) begin
          r_rptr   <= (r_rgnt == LAST_IDX) ? '0 : r_rgnt + 1'b1;
          r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Read path forwarding between the granted master and the slave
  always_comb begin
    s_araddr  = m_araddr[r_rgnt*ADDR_W +: ADDR_W];
    s_arvalid = (r_rstate == R_ADDR) & m_arvalid[r_rgnt];
    s_rready  = (r_rstate == R_DATA) & m_rready[r_rgnt];
    m_arready = '0;
    m_rvalid  = '0;
    if (r_rstate == R_ADDR) m_arready[r_rgnt] = s_arready;
    if (r_rstate == R_DATA) m_rvalid[r_rgnt]  = s_rvalid;
  end

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;

  // Write channel FSM: AW and W complete in any order before the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_wgnt    <= '0;
      r_wptr    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (w_wany) begin
          r_wgnt   <= w_wpick;
          r_wstate <= W_REQ;
        end
        W_REQ: begin
          // Completion includes a handshake landing this cycle, so flags never
          // need a separate clear cycle.
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        W_RESP: if (w_b_hs) begin
          r_wptr   <= (r_wgnt == LAST_IDX) ? '0 : r_wgnt + 1'b1;
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Write path forwarding; each half is masked once it has handshaken
  always_comb begin
    s_awaddr  = m_awaddr[r_wgnt*ADDR_W +: ADDR_W];
    s_wdata   = m_wdata[r_wgnt*DATA_W +: DATA_W];
    s_wstrb   = m_wstrb[r_wgnt*STRB_W +: STRB_W];
    s_awvalid = (r_wstate == W_REQ) & ~r_aw_done & m_awvalid[r_wgnt];
    s_wvalid  = (r_wstate == W_REQ) & ~r_w_done  & m_wvalid[r_wgnt];
    s_bready  = (r_wstate == W_RESP) & m_bready[r_wgnt];
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    if (r_wstate == W_REQ) begin
      m_awready[r_wgnt] = ~r_aw_done & s_awready;
      m_wready[r_wgnt]  = ~r_w_done  & s_wready;
    end
    if (r_wstate == W_RESP) m_bvalid[r_wgnt] = s_bvalid;
  end

  assign m_bresp = s_bresp;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_rd [N_MASTERS];
  logic [31:0] r_perf_wr [N_MASTERS];

  // Per-master completion counters, wrapping modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        r_perf_rd[k] <= '0;
        r_perf_wr[k] <= '0;
      end
    end else begin
      if ((r_rstate == R_DATA) && w_r_hs) r_perf_rd[r_rgnt] <= r_perf_rd[r_rgnt] + 32'd1;
      if ((r_wstate == W_RESP) && w_b_hs) r_perf_wr[r_wgnt] <= r_perf_wr[r_wgnt] + 32'd1;
    end
  end

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_perf
    assign perf_rd_cnt[g*32 +: 32] = r_perf_rd[g];
    assign perf_wr_cnt[g*32 +: 32] = r_perf_wr[g];
  end
`endif

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter with four masters.
module tb_axi_lite_rr_arbiter;
  import axi_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   m_araddr;
  logic [N-1:0]      m_arvalid, m_arready;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic [N-1:0]      m_rvalid, m_rready;
  logic [N*AW-1:0]   m_awaddr;
  logic [N-1:0]      m_awvalid, m_awready;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic [N-1:0]      m_wvalid, m_wready;
  logic [1:0]        m_bresp;
  logic [N-1:0]      m_bvalid, m_bready;
  logic [AW-1:0]     s_araddr;
  logic              s_arvalid, s_arready;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid, s_rready;
  logic [AW-1:0]     s_awaddr;
  logic              s_awvalid, s_awready;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_wvalid, s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid, s_bready;
`ifdef ARB_PERF_CNT_EN
  logic [N*32-1:0]   perf_rd_cnt, perf_wr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  axi_lite_rr_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STRB_W    (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_rd_cnt (perf_rd_cnt),
    .perf_wr_cnt (perf_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (observed timeout, expected finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read from master k; starts with the arbiter read side idle and k requesting.
  task automatic rd_txn(input int k, input logic [31:0] addr, input logic [31:0] data, input bit keep);
    tick();
    chk("ar_valid", s_arvalid, 1);
    chk("ar_addr", s_araddr, addr);
    chk("ar_ready", m_arready, 64'(1) << k);
    s_rdata = data;
    tick();
    if (!keep) m_arvalid[k] = 1'b0;
    #1;
    chk("r_valid", m_rvalid, 64'(1) << k);
    chk("r_data", m_rdata, data);
    chk("r_ready", s_rready, 1);
    tick();
  endtask

  // One write from master k with AW and W presented together.
  task automatic wr_txn(input int k, input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb);
    m_awaddr[k*AW +: AW] = addr;
    m_wdata[k*DW +: DW]  = data;
    m_wstrb[k*SW +: SW]  = strb;
    m_awvalid[k] = 1'b1;
    m_wvalid[k]  = 1'b1;
    tick();
    chk("aw_valid", s_awvalid, 1);
    chk("w_valid", s_wvalid, 1);
    chk("aw_addr", s_awaddr, addr);
    chk("w_data", s_wdata, data);
    chk("w_strb", s_wstrb, strb);
    chk("w_ready", m_wready, 64'(1) << k);
    tick();
    m_awvalid[k] = 1'b0;
    m_wvalid[k]  = 1'b0;
    #1;
    chk("b_valid", m_bvalid, 64'(1) << k);
    chk("b_ready", s_bready, 1);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    m_araddr  = {32'h8000000C, 32'h80000008, 32'h80000004, 32'h80000000};
    m_arvalid = 4'b0011;
    m_rready  = '1;
    m_awaddr  = '0;
    m_awvalid = '1;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = '1;
    m_bready  = '1;
    s_arready = 1'b1;
    s_rdata   = '0;
    s_rresp   = OKAY;
    s_rvalid  = 1'b1;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    s_bresp   = OKAY;
    s_bvalid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state with every request and slave response asserted
    chk("rst_arready", m_arready, 0);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_awready", m_awready, 0);
    chk("rst_wready", m_wready, 0);
    chk("rst_bvalid", m_bvalid, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_wvalid", s_wvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_s_bready", s_bready, 0);

    rst       = 1'b0;
    m_awvalid = '0;
    m_wvalid  = '0;
    #1;
    chk("idle_no_ar", s_arvalid, 0);

    // Masters 0 and 1 both request from pointer 0
    rd_txn(0, 32'h80000000, 32'h00000413, 1'b0);
    rd_txn(1, 32'h80000004, 32'h00000513, 1'b0);
    m_arvalid = 4'b1100;
    rd_txn(2, 32'h80000008, 32'h00000613, 1'b0);
    rd_txn(3, 32'h8000000C, 32'h00000713, 1'b0);

    // All four hold requests: strict rotation 0,1,2,3,0,1,2,3
    m_arvalid = '1;
    for (int i = 0; i < 8; i++) begin
      rd_txn(i % 4, 32'h80000000 + 32'(4 * (i % 4)), 32'h1000 + 32'(i), 1'b1);
    end
    m_arvalid = '0;

    // Lone requester beyond the pointer, then wrap from 3 to 0
    m_arvalid = 4'b0100;
    rd_txn(2, 32'h80000008, 32'h2002, 1'b0);
    m_arvalid = 4'b0011;
    rd_txn(0, 32'h80000000, 32'h2000, 1'b0);
    rd_txn(1, 32'h80000004, 32'h2001, 1'b0);

    // Master 1 presents W three cycles ahead of AW
    m_wdata[1*DW +: DW]  = 32'hDEADBEEF;
    m_wstrb[1*SW +: SW]  = 8'h0F;
    m_awaddr[1*AW +: AW] = 32'h80001000;
    m_wvalid[1] = 1'b1;
    tick();
    chk("wfirst_w_valid", s_wvalid, 1);
    chk("wfirst_w_data", s_wdata, 32'hDEADBEEF);
    chk("wfirst_w_strb", s_wstrb, 8'h0F);
    chk("wfirst_w_ready", m_wready, 4'b0010);
    chk("wfirst_no_aw", s_awvalid, 0);
    tick();
    m_wvalid[1] = 1'b0;
    #1;
    chk("wfirst_w_gone", s_wvalid, 0);
    chk("wfirst_no_b", m_bvalid, 0);
    tick();
    m_awvalid[1] = 1'b1;
    #1;
    chk("wfirst_aw_valid", s_awvalid, 1);
    chk("wfirst_aw_addr", s_awaddr, 32'h80001000);
    chk("wfirst_aw_ready", m_awready, 4'b0010);
    tick();
    m_awvalid[1] = 1'b0;
    #1;
    chk("wfirst_b_valid", m_bvalid, 4'b0010);
    chk("wfirst_bresp", m_bresp, OKAY);
    chk("wfirst_b_ready", s_bready, 1);
    chk("wfirst_no_w_resend", s_wvalid, 0);
    tick();
    chk("wfirst_b_done", m_bvalid, 0);

    // Concurrent read (master 0) and write (master 1), slave stalls R for 5 cycles
    m_arvalid[0] = 1'b1;
    m_awaddr[1*AW +: AW] = 32'h80002000;
    m_wdata[1*DW +: DW]  = 32'h12345678;
    m_wstrb[1*SW +: SW]  = 8'hFF;
    m_awvalid[1] = 1'b1;
    m_wvalid[1]  = 1'b1;
    s_rvalid     = 1'b0;
    tick();
    chk("cc_ar_ready", m_arready, 4'b0001);
    chk("cc_aw_ready", m_awready, 4'b0010);
    chk("cc_w_ready", m_wready, 4'b0010);
    chk("cc_aw_addr", s_awaddr, 32'h80002000);
    chk("cc_w_data", s_wdata, 32'h12345678);
    tick();
    m_arvalid[0] = 1'b0;
    m_awvalid[1] = 1'b0;
    m_wvalid[1]  = 1'b0;
    m_arvalid[2] = 1'b1;
    #1;
    chk("cc_b_valid", m_bvalid, 4'b0010);
    chk("cc_stall_rvalid", m_rvalid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cc_stall_rvalid", m_rvalid, 0);
      chk("cc_stall_no_grant", s_arvalid, 0);
      chk("cc_stall_arready", m_arready, 0);
    end
    chk("cc_b_done", m_bvalid, 0);
    s_rvalid = 1'b1;
    s_rdata  = 32'hCAFEF00D;
    s_rresp  = SLVERR;
    #1;
    chk("cc_r_valid", m_rvalid, 4'b0001);
    chk("cc_r_data", m_rdata, 32'hCAFEF00D);
    chk("cc_r_resp", m_rresp, SLVERR);
    tick();
    s_rresp = OKAY;
    rd_txn(2, 32'h80000008, 32'h3002, 1'b0);

    // Reset while the read is in its data phase and a write is stalled on W
    m_arvalid[3] = 1'b1;
    m_wvalid[2]  = 1'b1;
    s_wready     = 1'b0;
    tick();
    tick();
    m_arvalid[3] = 1'b0;
    #1;
    chk("pre_rst_rvalid", m_rvalid, 4'b1000);
    chk("pre_rst_wvalid", s_wvalid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", m_rvalid, 0);
    chk("mid_rst_rready", s_rready, 0);
    chk("mid_rst_wvalid", s_wvalid, 0);
    chk("mid_rst_arready", m_arready, 0);
    chk("mid_rst_s_arvalid", s_arvalid, 0);
    m_wvalid[2] = 1'b0;
    s_wready    = 1'b1;
    tick();
    rst       = 1'b0;
    m_arvalid = 4'b1001;
    rd_txn(0, 32'h80000000, 32'h4000, 1'b0);
    rd_txn(3, 32'h8000000C, 32'h4003, 1'b0);

`ifdef ARB_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_arvalid[1] = 1'b1;
      rd_txn(1, 32'h80000004, 32'h5000 + 32'(i), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      wr_txn(0, 32'h80003000 + 32'(4 * i), 32'h6000 + 32'(i), 8'hFF);
    end
    for (int k = 0; k < N; k++) begin
      chk("perf_rd", perf_rd_cnt[k*32 +: 32], (k == 1) ? 3 : 0);
      chk("perf_wr", perf_wr_cnt[k*32 +: 32], (k == 0) ? 2 : 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4-lite arbiter; next generation of the fixed two-master (IFU/LSU) memory arbiter.
- Read and write channels are arbitrated independently.
- Fairness is round-robin, with at most one outstanding transaction per channel.
- Sits between the fetch/load-store units (and future DMA/debug masters) and the memory/SoC slave port.

Parameters:
- N_MASTERS, 2, number of master ports (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STRB_W, 8, write-strobe width (codebase byte-mask convention).
- IDX_W, $clog2(N_MASTERS), grant index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m_araddr  in  N*ADDR_W  master read addresses, flattened; master i at slice i
- m_arvalid  in  N  read address valid per master
- m_arready  out  N  read address ready per master
- m_rdata  out  DATA_W  read data, broadcast to all masters
- m_rresp  out  2  read response, broadcast
- m_rvalid  out  N  read data valid per master
- m_rready  in  N  read data ready per master
- m_awaddr  in  N*ADDR_W  write addresses
- m_awvalid  in  N  write address valid per master
- m_awready  out  N  write address ready per master
- m_wdata  in  N*DATA_W  write data
- m_wstrb  in  N*STRB_W  write strobes
- m_wvalid  in  N  write data valid per master
- m_wready  out  N  write data ready per master
- m_bresp  out  2  write response, broadcast
- m_bvalid  out  N  write response valid per master
- m_bready  in  N  write response ready per master
- s_*  complementary single slave port: s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready, s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - Both FSMs go to IDLE; both RR pointers go to 0.
  - All m_*ready, m_*valid and s_*valid outputs are 0.
  - In-flight transactions are abandoned, not replayed.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any m_arvalid is set, register rgnt = pick(m_arvalid, rptr) and go to R_ADDR. One cycle of grant latency; no slave signal is driven in this cycle.
  - R_ADDR: s_araddr = slice[rgnt]; s_arvalid = m_arvalid[rgnt]; m_arready[rgnt] = s_arready. On s_arvalid & s_arready, go to R_DATA.
  - R_DATA: m_rvalid[rgnt] = s_rvalid; s_rready = m_rready[rgnt]. On handshake: rptr = (rgnt+1) mod N, go to R_IDLE.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE: a request is m_awvalid | m_wvalid. Register wgnt = pick(req, wptr) and go to W_REQ.
  - W_REQ: AW and W are forwarded from wgnt independently. Flags aw_done and w_done are set on their respective handshakes. Each valid is masked to 0 once its flag is set.
  - W_REQ ordering: AW and W may handshake in either order or in the same cycle. When both are done, clear the flags and go to W_RESP.
  - W_RESP: m_bvalid[wgnt] = s_bvalid; s_bready = m_bready[wgnt]. On handshake: wptr = (wgnt+1) mod N, go to W_IDLE.
- pick(req, ptr): the first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - A lone requester always wins.
  - Pointer wraps from N-1 to 0.
- Non-granted masters see ready = 0 and valid = 0 at all times.
- Masters must hold valid and payload until ready (AXI rule); the arbiter does not latch payload.
- The same master may hold the read grant and the write grant at the same time.
- Read and write pointers are independent.
- Slave ready/valid may be asserted in the same cycle as the corresponding valid/ready: zero extra latency.
- Broadcast buses (rdata/rresp/bresp) are don't-care whenever the matching per-master valid is 0.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_rd_cnt (N*32) and output perf_wr_cnt (N*32).
  - Each counter increments on completion of a read (R handshake) or write (B handshake) for its master.
  - Counters wrap modulo 2^32 and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package axi_arb_pkg:
  - AXI resp constants: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - Enums rd_state_t and wr_state_t.
- Sub-module rr_picker: combinational, parameter N; inputs req and ptr; outputs gnt_idx and any. Instantiated twice (read and write).

Test Plan:
- N=2: m_arvalid=2'b11 at reset release, rptr=0 → master0 granted first (araddr 0x80000000, rdata 0x00000413). Then master1 granted; rptr ends at 0.
- N=4: all four masters hold m_arvalid continuously for 8 reads → grant order 0,1,2,3,0,1,2,3.
- Write with W valid 3 cycles before AW (wdata 0xDEADBEEF, wstrb 0x0F, awaddr 0x80001000) → single slave write; bresp OKAY delivered only to the requester; other masters see bvalid=0.
- Concurrent traffic: master0 reads while master1 writes → both complete with no stall between channels. Slave holding s_rvalid low for 5 cycles → m_rvalid[0] stays 0 and no new read grant is issued.
- rst pulsed during R_DATA → all valids/readies 0 in the same cycle; after release the next request is granted from master0.
- ARB_PERF_CNT_EN defined, 3 reads from master1 and 2 writes from master0 → perf_rd_cnt[1]=3, perf_wr_cnt[0]=2, all other counters 0.
